// File: rtl/exception_sequencer_if.sv
// Bundle between the exception detector / pipeline and the exception sequencer.
// The slave modport is the sequencer side; the master modport is the pipeline side.
interface exception_sequencer_if;
  logic        exc_id_in;
  logic        exc_ex_in;
  logic        exc_mem_in;
  logic [2:0]  cause_in;
  logic [31:0] pc_id_in;
  logic [31:0] pc_ex_in;
  logic [31:0] pc_mem_in;
  logic        eret_in;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        flush_ex_mem;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic [31:0] epc_out;
  logic [2:0]  cause_out;
  logic        in_handler;
  logic        double_fault;
  logic        stall_out;
  logic [2:0]  fsm_state;

  modport slave (
    input  exc_id_in, exc_ex_in, exc_mem_in, cause_in,
    input  pc_id_in, pc_ex_in, pc_mem_in, eret_in,
    output flush_if_id, flush_id_ex, flush_ex_mem, pc_redirect, pc_target,
    output epc_out, cause_out, in_handler, double_fault, stall_out, fsm_state
  );

  modport master (
    output exc_id_in, exc_ex_in, exc_mem_in, cause_in,
    output pc_id_in, pc_ex_in, pc_mem_in, eret_in,
    input  flush_if_id, flush_id_ex, flush_ex_mem, pc_redirect, pc_target,
    input  epc_out, cause_out, in_handler, double_fault, stall_out, fsm_state
  );
endinterface

// File: rtl/exception_sequencer.sv
// Exception sequencer: picks the oldest faulting stage, saves EPC/CAUSE, flushes,
// redirects fetch to the per-cause vector, returns on eret, halts on double fault.
module exception_sequencer #(
  parameter logic [31:0] VEC_BASE  = 32'h0000_0100,
  parameter int          VEC_SHIFT = 4
) (
  input logic clk,
  input logic reset,
  exception_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FLUSH   = 3'd1,
    S_HANDLER = 3'd2,
    S_RETURN  = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    W_ID  = 2'd0,
    W_EX  = 2'd1,
    W_MEM = 2'd2
  } winner_t;

  state_t      state, state_nxt;
  winner_t     win_q, win_nxt;
  logic [31:0] epc_q, epc_nxt;
  logic [2:0]  cause_q;
  logic [31:0] vec_addr;
  logic        any_exc;

  assign any_exc  = bus.exc_id_in | bus.exc_ex_in | bus.exc_mem_in;
  assign vec_addr = VEC_BASE + ({29'd0, cause_q} << VEC_SHIFT);

  // Oldest instruction (furthest down the pipe) wins.
  always_comb begin
    win_nxt = W_ID;
    epc_nxt = bus.pc_id_in;
    if (bus.exc_mem_in) begin
      win_nxt = W_MEM;
      epc_nxt = bus.pc_mem_in;
    end else if (bus.exc_ex_in) begin
      win_nxt = W_EX;
      epc_nxt = bus.pc_ex_in;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (any_exc) state_nxt = S_FLUSH;
      S_FLUSH:   state_nxt = S_HANDLER;
      S_HANDLER: begin
        if (any_exc)          state_nxt = S_HALT;
        else if (bus.eret_in) state_nxt = S_RETURN;
      end
      S_RETURN:  state_nxt = S_IDLE;
      S_HALT:    state_nxt = S_HALT;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      win_q   <= W_ID;
      epc_q   <= 32'd0;
      cause_q <= 3'd0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && any_exc) begin
        win_q   <= win_nxt;
        epc_q   <= epc_nxt;
        cause_q <= bus.cause_in;
      end
    end
  end

  // Outputs decode only from state and saved registers, never from exc inputs.
  always_comb begin
    bus.flush_if_id  = 1'b0;
    bus.flush_id_ex  = 1'b0;
    bus.flush_ex_mem = 1'b0;
    bus.pc_redirect  = 1'b0;
    bus.pc_target    = 32'd0;
    bus.in_handler   = 1'b0;
    bus.double_fault = 1'b0;
    bus.stall_out    = 1'b0;
    case (state)
      S_FLUSH: begin
        bus.pc_redirect  = 1'b1;
        bus.pc_target    = vec_addr;
        bus.flush_if_id  = 1'b1;
        bus.flush_id_ex  = (win_q != W_ID);
        bus.flush_ex_mem = (win_q == W_MEM);
      end
      S_HANDLER: bus.in_handler = 1'b1;
      S_RETURN: begin
        bus.pc_redirect = 1'b1;
        bus.pc_target   = epc_q;
        bus.flush_if_id = 1'b1;
        bus.in_handler  = 1'b1;
      end
      S_HALT: begin
        bus.double_fault = 1'b1;
        bus.stall_out    = 1'b1;
        bus.flush_if_id  = 1'b1;
        bus.flush_id_ex  = 1'b1;
        bus.flush_ex_mem = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.epc_out   = epc_q;
  assign bus.cause_out = cause_q;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed bench for exception_sequencer: per-cycle scoreboard against a behavioural
// model, plus literal spot checks and a wrap-around vector-base instance.
module tb_exception_sequencer;

  localparam logic [31:0] BASE   = 32'h0000_0100;
  localparam logic [31:0] BASE_W = 32'hFFFF_FFF0;
  localparam int          W      = 74;

  logic clk = 1'b0;
  logic reset;

  exception_sequencer_if bus ();
  exception_sequencer_if bus_w ();

  exception_sequencer #(.VEC_BASE(BASE), .VEC_SHIFT(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  exception_sequencer #(.VEC_BASE(BASE_W), .VEC_SHIFT(4)) dut_w (
    .clk(clk), .reset(reset), .bus(bus_w)
  );

  assign bus_w.exc_id_in  = bus.exc_id_in;
  assign bus_w.exc_ex_in  = bus.exc_ex_in;
  assign bus_w.exc_mem_in = bus.exc_mem_in;
  assign bus_w.cause_in   = bus.cause_in;
  assign bus_w.pc_id_in   = bus.pc_id_in;
  assign bus_w.pc_ex_in   = bus.pc_ex_in;
  assign bus_w.pc_mem_in  = bus.pc_mem_in;
  assign bus_w.eret_in    = bus.eret_in;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_FLUSH = 1, M_HANDLER = 2, M_RETURN = 3, M_HALT = 4;
  int          m_mode  = M_IDLE;
  int          m_depth = 0;  // number of pipeline registers the winner flushes
  logic [31:0] m_epc   = 32'd0;
  logic [2:0]  m_cause = 3'd0;
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] model_vec(int mode, int depth, logic [31:0] epc,
                                             logic [2:0] cause);
    logic f1, f2, f3, red, inh, df, st;
    logic [31:0] tgt;
    f1 = 0; f2 = 0; f3 = 0; red = 0; inh = 0; df = 0; st = 0; tgt = 32'd0;
    if (mode == M_FLUSH) begin
      red = 1; tgt = BASE + 32'(cause) * 32'd16;
      f1 = (depth >= 1); f2 = (depth >= 2); f3 = (depth >= 3);
    end else if (mode == M_HANDLER) begin
      inh = 1;
    end else if (mode == M_RETURN) begin
      red = 1; tgt = epc; f1 = 1; inh = 1;
    end else if (mode == M_HALT) begin
      df = 1; st = 1; f1 = 1; f2 = 1; f3 = 1;
    end
    return {f1, f2, f3, red, tgt, epc, cause, inh, df, st};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_mode = M_IDLE; m_epc = 32'd0; m_cause = 3'd0; m_depth = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (bus.exc_id_in || bus.exc_ex_in || bus.exc_mem_in) begin
          if (bus.exc_mem_in)     begin m_depth = 3; m_epc = bus.pc_mem_in; end
          else if (bus.exc_ex_in) begin m_depth = 2; m_epc = bus.pc_ex_in;  end
          else                    begin m_depth = 1; m_epc = bus.pc_id_in;  end
          m_cause = bus.cause_in;
          m_mode  = M_FLUSH;
        end
        M_FLUSH:   m_mode = M_HANDLER;
        M_HANDLER: begin
          if (bus.exc_id_in || bus.exc_ex_in || bus.exc_mem_in) m_mode = M_HALT;
          else if (bus.eret_in) m_mode = M_RETURN;
        end
        M_RETURN:  m_mode = M_IDLE;
        default:   m_mode = M_HALT;
      endcase
    end
    exp_q.push_back(model_vec(m_mode, m_depth, m_epc, m_cause));
  end

  // ---------------- scoreboard compare (opposite edge) ----------------
  always @(negedge clk) begin
    logic [W-1:0] got, want;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = {bus.flush_if_id, bus.flush_id_ex, bus.flush_ex_mem, bus.pc_redirect,
              bus.pc_target, bus.epc_out, bus.cause_out, bus.in_handler,
              bus.double_fault, bus.stall_out};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t got=%h want=%h", $time, got, want);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.exc_id_in = 0; bus.exc_ex_in = 0; bus.exc_mem_in = 0;
    bus.cause_in = 3'd0; bus.eret_in = 0;
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic check_all_zero(string name);
    check({name, "_outs"}, {25'd0, bus.flush_if_id, bus.flush_id_ex, bus.flush_ex_mem,
                            bus.pc_redirect, bus.in_handler, bus.double_fault,
                            bus.stall_out}, 32'd0);
    check({name, "_tgt"}, bus.pc_target, 32'd0);
    check({name, "_epc"}, bus.epc_out, 32'd0);
    check({name, "_cause"}, {29'd0, bus.cause_out}, 32'd0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    clear_inputs();
    bus.pc_id_in = 32'h44; bus.pc_ex_in = 32'h40; bus.pc_mem_in = 32'h3c;
    reset = 1;
    tick(); tick();
    reset = 0;
    check_all_zero("reset");
    check("reset_wrap_tgt", bus_w.pc_target, 32'd0);

    // EX exception, cause 4
    bus.exc_ex_in = 1; bus.cause_in = 3'd4;
    tick(); clear_inputs();
    check("t1_flushes", {29'd0, bus.flush_if_id, bus.flush_id_ex, bus.flush_ex_mem}, 32'b110);
    check("t1_redirect", {31'd0, bus.pc_redirect}, 32'd1);
    check("t1_target", bus.pc_target, 32'h140);
    check("t1_epc", bus.epc_out, 32'h40);
    check("t1_cause", {29'd0, bus.cause_out}, 32'd4);
    tick();
    check("t1_in_handler", {31'd0, bus.in_handler}, 32'd1);
    check("t1_handler_redirect", {31'd0, bus.pc_redirect}, 32'd0);

    // eret returns to EPC
    bus.eret_in = 1;
    tick(); clear_inputs();
    check("t3_ret_redirect", {31'd0, bus.pc_redirect}, 32'd1);
    check("t3_ret_target", bus.pc_target, 32'h40);
    check("t3_ret_flush_if_id", {31'd0, bus.flush_if_id}, 32'd1);
    tick();
    check("t3_idle_in_handler", {31'd0, bus.in_handler}, 32'd0);

    // eret in IDLE is ignored
    bus.eret_in = 1;
    tick(); clear_inputs();
    check("t6_eret_idle_redirect", {31'd0, bus.pc_redirect}, 32'd0);
    check("t6_eret_idle_epc", bus.epc_out, 32'h40);
    tick();

    // all three stages fault: MEM wins
    bus.pc_mem_in = 32'h30;
    bus.exc_id_in = 1; bus.exc_ex_in = 1; bus.exc_mem_in = 1; bus.cause_in = 3'd1;
    tick(); clear_inputs();
    check("t2_epc", bus.epc_out, 32'h30);
    check("t2_flushes", {29'd0, bus.flush_if_id, bus.flush_id_ex, bus.flush_ex_mem}, 32'b111);
    check("t2_target", bus.pc_target, 32'h110);
    tick();
    check("t2_flush_done", {29'd0, bus.flush_if_id, bus.flush_id_ex, bus.flush_ex_mem}, 32'b000);

    // double fault with simultaneous eret -> HALT
    bus.exc_mem_in = 1; bus.eret_in = 1; bus.pc_mem_in = 32'h80; bus.cause_in = 3'd6;
    tick(); clear_inputs();
    repeat (20) tick();
    check("t4_double_fault", {31'd0, bus.double_fault}, 32'd1);
    check("t4_stall", {31'd0, bus.stall_out}, 32'd1);
    check("t4_epc_kept", bus.epc_out, 32'h30);
    reset = 1;
    tick();
    reset = 0;
    check_all_zero("t4_reset");

    // ID exception, cause 2; wrap instance vectors to 0x10; exc during FLUSH ignored
    bus.pc_id_in = 32'h200; bus.exc_id_in = 1; bus.cause_in = 3'd2;
    tick();
    bus.cause_in = 3'd7; bus.pc_id_in = 32'h204;
    check("t5_wrap_target", bus_w.pc_target, 32'h0000_0010);
    check("t5_target", bus.pc_target, 32'h120);
    check("t5_flushes", {29'd0, bus.flush_if_id, bus.flush_id_ex, bus.flush_ex_mem}, 32'b100);
    tick(); clear_inputs();
    check("flush_ignores_exc", {31'd0, bus.in_handler}, 32'd1);
    check("flush_ignores_exc_df", {31'd0, bus.double_fault}, 32'd0);
    check("flush_ignores_exc_epc", bus.epc_out, 32'h200);
    bus.eret_in = 1;
    tick(); clear_inputs();
    tick();

    // reset during FLUSH
    bus.exc_ex_in = 1; bus.cause_in = 3'd3;
    tick(); clear_inputs();
    reset = 1;
    tick();
    reset = 0;
    check_all_zero("t6_reset_in_flush");

    // reset during RETURN
    bus.exc_id_in = 1; bus.cause_in = 3'd5;
    tick(); clear_inputs();
    tick();
    bus.eret_in = 1;
    tick(); clear_inputs();
    reset = 1;
    tick();
    reset = 0;
    check_all_zero("reset_in_return");
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
